// File: rtl/vga_sync_monitor_pkg.sv
// Shared VGA timing constants, monitor state encoding and a sync-window helper
// used by the sync monitor.
package vga_sync_monitor_pkg;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned ERR_W = 8;

   // 640x480 @ 60 Hz: 800 x 525 totals
   localparam int unsigned H_DISPLAY     = 640;
   localparam int unsigned H_FRONT       = 16;
   localparam int unsigned H_PULSE       = 96;
   localparam int unsigned H_SYNC_CYCLES = 800;
   localparam int unsigned V_DISPLAY     = 480;
   localparam int unsigned V_FRONT       = 10;
   localparam int unsigned V_PULSE       = 2;
   localparam int unsigned V_SYNC_CYCLES = 525;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_e;

   typedef struct packed {
      logic hs;
      logic vs;
   } sync_pair_t;

   // True when pos lies in the half-open window [lo, lo+len)
   function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                      input int unsigned      lo,
                                      input int unsigned      len);
      return (32'(pos) >= lo) && (32'(pos) < (lo + len));
   endfunction

endpackage

// File: rtl/vga_sync_monitor.sv
// Recovers raster position from HS/VS, verifies the sync timing against a
// locally predicted raster, and reports lock, visible area and violations.
module vga_sync_monitor
   import vga_sync_monitor_pkg::*;
#(
   parameter int unsigned H_DISP  = H_DISPLAY,
   parameter int unsigned H_FP    = H_FRONT,
   parameter int unsigned H_PW    = H_PULSE,
   parameter int unsigned H_TOTAL = H_SYNC_CYCLES,
   parameter int unsigned V_DISP  = V_DISPLAY,
   parameter int unsigned V_FP    = V_FRONT,
   parameter int unsigned V_PW    = V_PULSE,
   parameter int unsigned V_TOTAL = V_SYNC_CYCLES
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             VGA_HS,
   input  logic             VGA_VS,
   output logic [CNT_W-1:0] h_count,
   output logic [CNT_W-1:0] v_count,
   output logic             pixel_active,
   output logic             locked,
   output logic             frame_start,
   output logic             timing_error,
   output logic [ERR_W-1:0] error_count
);

   // The sample pipeline delays the stream by two cycles, so a VS rise seen
   // here corresponds to the first VS line at h=0.
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISP + V_FP);

   mon_state_e       state;
   sync_pair_t       smp_d;
   sync_pair_t       smp_dd;

   logic [CNT_W-1:0] h_inc;
   logic [CNT_W-1:0] v_inc;
   logic             pred_hs;
   logic             pred_vs;
   logic             mismatch;
   logic             vs_rise;
   logic             visible;
   logic             origin;

   // Next raster position with line and frame wrap
   always_comb begin
      h_inc = h_count + CNT_W'(1);
      v_inc = v_count;
      if (32'(h_count) >= (H_TOTAL - 1)) begin
         h_inc = '0;
         if (32'(v_count) >= (V_TOTAL - 1)) begin
            v_inc = '0;
         end else begin
            v_inc = v_count + CNT_W'(1);
         end
      end
   end

   assign pred_hs  = in_window(h_inc, H_DISP + H_FP, H_PW);
   assign pred_vs  = in_window(v_inc, V_DISP + V_FP, V_PW);
   assign mismatch = (state != SEARCH) &&
                     ((smp_d.hs != pred_hs) || (smp_d.vs != pred_vs));
   assign vs_rise  = (smp_d.vs != smp_dd.vs) && smp_d.vs;
   assign visible  = (32'(h_inc) < H_DISP) && (32'(v_inc) < V_DISP);
   assign origin   = (h_inc == '0) && (v_inc == '0);

   // Lock FSM, position counters and all registered outputs
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= SEARCH;
         smp_d        <= '0;
         smp_dd       <= '0;
         h_count      <= '0;
         v_count      <= '0;
         locked       <= 1'b0;
         pixel_active <= 1'b0;
         frame_start  <= 1'b0;
         timing_error <= 1'b0;
         error_count  <= '0;
      end else begin
         smp_d        <= '{hs: VGA_HS, vs: VGA_VS};
         smp_dd       <= smp_d;
         timing_error <= mismatch;
         pixel_active <= 1'b0;
         frame_start  <= 1'b0;
         if (mismatch && (error_count != '1)) begin
            error_count <= error_count + ERR_W'(1);
         end

         unique case (state)
            SEARCH: begin
               locked  <= 1'b0;
               h_count <= '0;
               if (vs_rise) begin
                  state   <= ACQUIRE;
                  v_count <= VS_START;
               end else begin
                  v_count <= '0;
               end
            end
            ACQUIRE, LOCKED: begin
               if (mismatch) begin
                  state   <= SEARCH;
                  locked  <= 1'b0;
                  h_count <= '0;
                  v_count <= '0;
               end else begin
                  h_count <= h_inc;
                  v_count <= v_inc;
                  // A clean VS rise closes one fully verified frame
                  if (vs_rise || (state == LOCKED)) begin
                     state        <= LOCKED;
                     locked       <= 1'b1;
                     pixel_active <= visible;
                     frame_start  <= origin;
                  end
               end
            end
            default: begin
               state   <= SEARCH;
               locked  <= 1'b0;
               h_count <= '0;
               v_count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed + randomized bench for vga_sync_monitor on a reduced raster
// (16x10 totals) so whole-frame scenarios stay short.
module tb_vga_sync_monitor;

   localparam int HD = 8;
   localparam int HF = 2;
   localparam int HP = 3;
   localparam int HT = 16;
   localparam int VD = 6;
   localparam int VF = 1;
   localparam int VP = 2;
   localparam int VT = 10;
   localparam int FT = HT * VT;
   localparam int VS_LINE = VD + VF;

   logic       CLK;
   logic       RST_N;
   logic       VGA_HS;
   logic       VGA_VS;
   logic [9:0] h_count;
   logic [9:0] v_count;
   logic       pixel_active;
   logic       locked;
   logic       frame_start;
   logic       timing_error;
   logic [7:0] error_count;

   vga_sync_monitor #(
      .H_DISP (HD), .H_FP (HF), .H_PW (HP), .H_TOTAL (HT),
      .V_DISP (VD), .V_FP (VF), .V_PW (VP), .V_TOTAL (VT)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .VGA_HS       (VGA_HS),
      .VGA_VS       (VGA_VS),
      .h_count      (h_count),
      .v_count      (v_count),
      .pixel_active (pixel_active),
      .locked       (locked),
      .frame_start  (frame_start),
      .timing_error (timing_error),
      .error_count  (error_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Generator raster position and the positions driven on earlier cycles
   int   gh = 0, gv = 0;
   int   prv_h = 0, prv_v = 0;
   int   dly_h = 0, dly_v = 0;
   logic flip_hs = 1'b0, flip_vs = 1'b0, kill_vs = 1'b0, rst_drv = 1'b0;

   // Reference model: phase 0=searching 1=verifying 2=locked; the assumed
   // raster position is the VS-start position plus cycles since acquisition
   int   m_phase = 0;
   int   m_k0    = 0;
   int   m_errs  = 0;
   logic m_d_hs = 1'b0, m_d_vs = 1'b0, m_dd_hs = 1'b0, m_dd_vs = 1'b0;
   int   e_h = 0, e_v = 0, e_ec = 0;
   logic e_pa = 1'b0, e_lk = 1'b0, e_fs = 1'b0, e_te = 1'b0;

   function automatic logic hs_ideal(input int h);
      return (h >= HD + HF) && (h < HD + HF + HP);
   endfunction

   function automatic logic vs_ideal(input int v);
      return (v >= VS_LINE) && (v < VS_LINE + VP);
   endfunction

   function automatic int frame_pos();
      return (VS_LINE * HT + (cyc - m_k0)) % FT;
   endfunction

   function automatic logic [31:0] obs_vec();
      return {h_count, v_count, pixel_active, locked, frame_start, timing_error, error_count};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {10'(e_h), 10'(e_v), e_pa, e_lk, e_fs, e_te, 8'(e_ec)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s @cyc %0d: observed 0x%h required 0x%h", tag, cyc, obs, req);
      end
      if (errors >= 40) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   endtask

   task automatic model_edge(input logic rst, input logic hs, input logic vs);
      int   pos;
      logic rise;
      logic te;
      te = 1'b0;
      if (!rst) begin
         m_phase = 0;
         m_errs  = 0;
         m_d_hs  = 1'b0; m_d_vs  = 1'b0;
         m_dd_hs = 1'b0; m_dd_vs = 1'b0;
         e_h = 0; e_v = 0; e_ec = 0;
         e_pa = 1'b0; e_lk = 1'b0; e_fs = 1'b0; e_te = 1'b0;
      end else begin
         rise = m_d_vs && !m_dd_vs;
         if (m_phase == 0) begin
            if (rise) begin
               m_phase = 1;
               m_k0    = cyc;
            end
         end else begin
            pos = frame_pos();
            if ((m_d_hs != hs_ideal(pos % HT)) || (m_d_vs != vs_ideal(pos / HT))) begin
               te      = 1'b1;
               m_phase = 0;
               if (m_errs < 255) m_errs++;
            end else if (rise) begin
               m_phase = 2;
            end
         end
         if (m_phase == 0) begin
            e_h = 0;
            e_v = 0;
         end else begin
            pos = frame_pos();
            e_h = pos % HT;
            e_v = pos / HT;
         end
         e_lk = (m_phase == 2);
         e_pa = e_lk && (e_h < HD) && (e_v < VD);
         e_fs = e_lk && (e_h == 0) && (e_v == 0);
         e_te = te;
         e_ec = m_errs;
         m_dd_hs = m_d_hs; m_dd_vs = m_d_vs;
         m_d_hs  = hs;     m_d_vs  = vs;
      end
   endtask

   // One clock: drive generator outputs, advance model and generator, compare
   task automatic tick();
      VGA_HS = hs_ideal(gh) ^ flip_hs;
      VGA_VS = (vs_ideal(gv) ^ flip_vs) & ~kill_vs;
      RST_N  = rst_drv;
      @(posedge CLK);
      cyc++;
      model_edge(rst_drv, VGA_HS, VGA_VS);
      dly_h = prv_h; dly_v = prv_v;
      prv_h = gh;    prv_v = gv;
      if (gh == HT - 1) begin
         gh = 0;
         gv = (gv == VT - 1) ? 0 : gv + 1;
      end else begin
         gh++;
      end
      #1;
      chk("model", obs_vec(), exp_vec());
   endtask

   task automatic wait_locked(input string tag, input int budget);
      int n = 0;
      while ((locked !== 1'b1) && (n < budget)) begin
         tick();
         n++;
      end
      chk(tag, 32'(locked), 32'd1);
   endtask

   // Advance until the generator is about to drive position (h, v)
   task automatic run_to(input int h, input int v);
      int n = 0;
      while (!((gh == h) && (gv == v)) && (n <= FT)) begin
         tick();
         n++;
      end
      if (!((gh == h) && (gv == v))) chk("run_to_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int seen_fs = 0, since = 0, pa_cnt = 0;
      int te_seen = 0;
      int r;

      VGA_HS = 1'b0;
      VGA_VS = 1'b0;
      RST_N  = 1'b0;
      repeat (4) tick();
      chk("reset_state", obs_vec(), 32'd0);
      rst_drv = 1'b1;

      // Clean stream
      wait_locked("clean_lock", 2 * FT);
      for (int i = 0; i < 3 * FT; i++) begin
         tick();
         chk("clean_no_err", 32'(timing_error), 32'd0);
         if (locked) chk("h_v_delay2", 32'({h_count, v_count}), 32'({10'(dly_h), 10'(dly_v)}));
         if (frame_start) begin
            if (seen_fs > 0) begin
               chk("frame_interval", 32'(since), 32'(FT));
               chk("pixels_per_frame", 32'(pa_cnt), 32'(HD * VD));
            end
            seen_fs++;
            since  = 0;
            pa_cnt = 0;
         end
         since++;
         pa_cnt += int'(pixel_active);
      end
      chk("frame_starts_seen", 32'(seen_fs), 32'd3);

      // HS pulse stretched by one cycle
      run_to(HD + HF + HP, 2);
      flip_hs = 1'b1;
      tick();
      flip_hs = 1'b0;
      tick();
      chk("stretch_err", 32'(timing_error), 32'd1);
      chk("stretch_unlock", 32'(locked), 32'd0);
      chk("stretch_count", 32'(error_count), 32'd1);
      tick();
      chk("stretch_single", 32'(timing_error), 32'd0);
      wait_locked("stretch_relock", 2 * FT);

      // One VS pulse suppressed
      run_to(0, VS_LINE);
      kill_vs = 1'b1;
      tick();
      tick();
      chk("vs_supp_err", 32'(timing_error), 32'd1);
      chk("vs_supp_unlock", 32'(locked), 32'd0);
      chk("vs_supp_search", 32'({h_count, v_count}), 32'd0);
      while (vs_ideal(gv)) tick();
      kill_vs = 1'b0;
      wait_locked("vs_supp_relock", 2 * FT);
      chk("vs_supp_count", 32'(error_count), 32'd2);

      // Reset pulse mid-frame
      run_to(5, 3);
      rst_drv = 1'b0;
      tick();
      rst_drv = 1'b1;
      chk("reset_mid", obs_vec(), 32'd0);
      wait_locked("reset_relock", 2 * FT);
      chk("reset_errcnt", 32'(error_count), 32'd0);

      // 300 glitches, each while verifying; every 7th also flips VS
      for (int i = 0; i < 300; i++) begin
         run_to(0, VS_LINE);
         r = int'($urandom_range(FT - 20, VP * HT + 3));
         repeat (r) tick();
         flip_hs = 1'b1;
         flip_vs = ((i % 7) == 0);
         tick();
         flip_hs = 1'b0;
         flip_vs = 1'b0;
         tick();
         te_seen += int'(timing_error);
      end
      chk("glitch_pulses", 32'(te_seen), 32'd300);
      chk("err_saturate", 32'(error_count), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock and reset ports are CLK and RST_N.
REQ-002 CLK  input  1  pixel clock, the same clock that drives the sync generator; no CDC.
REQ-003 RST_N  input  1  synchronous active-low reset.
REQ-004 VGA_HS  input  1  horizontal sync, active-high pulse, as produced by the team's sync generator.
REQ-005 VGA_VS  input  1  vertical sync, active-high pulse.
REQ-006 h_count  output  10  recovered horizontal position.
REQ-007 v_count  output  10  recovered vertical position.
REQ-008 pixel_active  output  1  recovered position lies in the visible area.
REQ-009 locked  output  1  timing verified; recovered counters valid.
REQ-010 frame_start  output  1  one-cycle pulse at recovered (0,0) while locked.
REQ-011 timing_error  output  1  one-cycle pulse on any sync violation.
REQ-012 error_count  output  8  saturating count of timing_error pulses.

Function
REQ-013 VGA_HS and VGA_VS SHALL each be registered twice (hs_d/hs_dd, vs_d/vs_dd); edges are detected as d != dd.
REQ-014 The FSM SHALL have three states, SEARCH, ACQUIRE and LOCKED, with reset state SEARCH.
REQ-015 SEARCH: h_count and v_count SHALL be held at 0; a VS rising edge SHALL load counters so that h=0, v=V_DISPLAY+V_FRONT (2-cycle-delayed frame), then go to ACQUIRE.
REQ-016 ACQUIRE/LOCKED: h SHALL increment every cycle and wrap at H_SYNC_CYCLES-1 to 0; on wrap, v SHALL increment and wrap at V_SYNC_CYCLES-1 to 0.
REQ-017 Predicted HS SHALL be high for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_PULSE); predicted VS SHALL be high for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_PULSE).
REQ-018 Any cycle where hs_d or vs_d differs from its prediction SHALL raise timing_error for exactly that cycle, even if several mismatches coincide.
REQ-019 On error in ACQUIRE or LOCKED, the state SHALL go to SEARCH next cycle, locked SHALL deassert, and counters SHALL clear to 0.
REQ-020 ACQUIRE SHALL go to LOCKED on the next error-free VS rising edge, i.e. one full frame of V_SYNC_CYCLES lines verified.
REQ-021 When LOCKED, h_count/v_count SHALL equal the generator's counters from exactly 2 CLK cycles earlier.
REQ-022 pixel_active SHALL be locked && h<H_DISPLAY && v<V_DISPLAY.
REQ-023 frame_start SHALL pulse when locked && h==0 && v==0.
REQ-024 error_count SHALL increment on each timing_error pulse and saturate at 255 without wrapping.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While RST_N=0 at a CLK edge, the block SHALL set state=SEARCH and h_count=0, v_count=0, locked=0, pixel_active=0, frame_start=0, timing_error=0, error_count=0, and clear all sync sample registers to 0.
REQ-027 Reset asserted mid-frame SHALL take effect at the next CLK edge and SHALL force reacquisition from SEARCH.

Structure
REQ-028 H_DISPLAY, H_FRONT, H_PULSE, H_SYNC_CYCLES, V_DISPLAY, V_FRONT, V_PULSE and V_SYNC_CYCLES SHALL come from the shared constants.v (640x480: 800x525 totals); the FSM state encodings SHALL also live there.
REQ-029 The block SHALL be implemented flat, with no sub-modules; the counter/predictor is not split out.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Clean stream: generator driving the monitor from reset -> locked=1 before cycle 840000; then h_count/v_count = generator values delayed 2 cycles; timing_error never pulses.
- Locked, one HS pulse stretched to 97 cycles -> single timing_error pulse at the 97th cycle; locked=0; error_count=1; relock within 2 frames.
- Locked, one VS pulse suppressed -> timing_error at the expected VS rise (v=490, h=0, delayed 2); state SEARCH.
- Locked, RST_N low for 1 cycle at h=300, v=100 -> all outputs 0 next cycle; relock after the next verified frame.
- Per locked frame: pixel_active high for exactly 307200 cycles; frame_start pulses exactly once, 420000 cycles apart.
- 300 injected HS glitches -> error_count=255, no wrap.
